// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the two-requester logic-unit arbiter: op codes,
// FSM state encodings and the default datapath width.
package logic_unit_arbiter_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational bitwise logic unit shared by both requesters.
// Result is exactly WIDTH bits with no carry or flags.
import logic_unit_arbiter_pkg::*;

module logic_unit #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_NOR:  y = ~(a | b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of one shared logic unit: IDLE grants and
// latches a request, EXEC computes, RESP holds the result until consumed.
import logic_unit_arbiter_pkg::*;

module logic_unit_arbiter #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready
);

  state_t                 state;
  logic                   ptr;
  logic [1:0]             lat_op;
  logic [WIDTH-1:0]       lat_a;
  logic [WIDTH-1:0]       lat_b;
  logic                   lat_id;

  logic [1:0][1:0]        op_vec;
  logic [1:0][WIDTH-1:0]  a_vec;
  logic [1:0][WIDTH-1:0]  b_vec;
  logic                   gnt_vld;
  logic                   gid;
  logic                   accept;
  logic [WIDTH-1:0]       lu_y;

  assign op_vec = {req_op1, req_op0};
  assign a_vec  = {req_a1, req_a0};
  assign b_vec  = {req_b1, req_b0};

  // Grant only in IDLE and never while reset is asserted; ptr breaks ties.
  always_comb begin
    gnt_vld = 1'b0;
    gid     = 1'b0;
    if (!rst && state == ST_IDLE) begin
      unique case (req_valid)
        2'b01:   begin gnt_vld = 1'b1; gid = 1'b0; end
        2'b10:   begin gnt_vld = 1'b1; gid = 1'b1; end
        2'b11:   begin gnt_vld = 1'b1; gid = ptr;  end
        default: begin gnt_vld = 1'b0; gid = 1'b0; end
      endcase
    end
  end

  assign req_ready = gnt_vld ? (gid ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(req_valid & req_ready);

  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .op (lat_op),
    .a  (lat_a),
    .b  (lat_b),
    .y  (lu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      lat_op    <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_op <= op_vec[gid];
            lat_a  <= a_vec[gid];
            lat_b  <= b_vec[gid];
            lat_id <= gid;
            ptr    <= ~gid;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= lu_y;
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with hand-computed expected values.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready;

  int total = 0;
  int bad   = 0;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    step(); step();

    // Reset state; req_ready must stay low even with a valid request
    req_valid = 2'b01; #1;
    chk("rst_ready", 32'(req_ready), 32'(2'b00));
    chk("rst_valid", 32'(rsp_valid), 32'(1'b0));
    chk("rst_data",  rsp_data, 32'h0);
    chk("rst_id",    32'(rsp_id), 32'(1'b0));

    // Single NOR request from requester 0
    rst = 1'b0; req_op0 = 2'b00; req_a0 = 32'hF0F0F0F0; req_b0 = 32'h0000FFFF; #1;
    chk("a_ready_idle", 32'(req_ready), 32'(2'b01));
    step(); req_valid = 2'b00;
    chk("a_exec_ready", 32'(req_ready), 32'(2'b00));
    chk("a_exec_valid", 32'(rsp_valid), 32'(1'b0));
    step();
    chk("a_rsp_valid", 32'(rsp_valid), 32'(1'b1));
    chk("a_rsp_data",  rsp_data, 32'h0F0F0000);
    chk("a_rsp_id",    32'(rsp_id), 32'(1'b0));
    step();
    chk("a_idle_valid", 32'(rsp_valid), 32'(1'b0));

    // Both valid from reset: req0 (AND) first, then req1 (XOR)
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 2'b11;
    req_op0 = 2'b01; req_a0 = 32'hAAAA5555; req_b0 = 32'h0F0F0F0F;
    req_op1 = 2'b11; req_a1 = 32'hFFFF0000; req_b1 = 32'h00FF00FF; #1;
    chk("b_ready0", 32'(req_ready), 32'(2'b01));
    step(); req_valid = 2'b10;
    step();
    chk("b_rsp0_data", rsp_data, 32'h0A0A0505);
    chk("b_rsp0_id",   32'(rsp_id), 32'(1'b0));
    chk("b_resp_ready", 32'(req_ready), 32'(2'b00));
    step();
    chk("b_ready1", 32'(req_ready), 32'(2'b10));
    step(); req_valid = 2'b00;
    step();
    chk("b_rsp1_data", rsp_data, 32'hFF0000FF);
    chk("b_rsp1_id",   32'(rsp_id), 32'(1'b1));
    step();

    // Continuous contention: 8 ops alternate 0,1,... spaced 3 cycles apart
    req_op0 = 2'b10; req_a0 = 32'h12340000; req_b0 = 32'h00005678;
    req_op1 = 2'b00; req_a1 = 32'hFFFF0000; req_b1 = 32'h0000FF00;
    req_valid = 2'b11; #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("c_ready_%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      chk($sformatf("c_exec_valid_%0d", k), 32'(rsp_valid), 32'h0);
      step();
      chk($sformatf("c_rsp_valid_%0d", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("c_rsp_id_%0d", k), 32'(rsp_id), 32'(k % 2));
      chk($sformatf("c_rsp_data_%0d", k), rsp_data, (k % 2 == 0) ? 32'h12345678 : 32'h000000FF);
      step();
    end
    req_valid = 2'b00; #1;

    // Backpressure: hold RESP 5 cycles, req1 waits and is accepted on IDLE
    rsp_ready = 1'b0;
    req_op0 = 2'b11; req_a0 = 32'hFF00FF00; req_b0 = 32'h0F0F0F0F;
    req_valid = 2'b01; #1;
    step();
    req_valid = 2'b10; req_op1 = 2'b01; req_a1 = 32'hFFFF0000; req_b1 = 32'h12345678;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("d_hold_valid_%0d", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("d_hold_data_%0d", i), rsp_data, 32'hF00FF00F);
      chk($sformatf("d_hold_ready_%0d", i), 32'(req_ready), 32'h0);
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    chk("d_idle_valid", 32'(rsp_valid), 32'h0);
    chk("d_idle_ready", 32'(req_ready), 32'(2'b10));
    step(); req_valid = 2'b00;
    chk("d_exec_ready", 32'(req_ready), 32'h0);
    step();
    chk("d_rsp_data", rsp_data, 32'h12340000);
    chk("d_rsp_id",   32'(rsp_id), 32'(1'b1));
    step();

    // Reset during EXEC abandons the transaction
    req_op0 = 2'b01; req_a0 = 32'hFFFFFFFF; req_b0 = 32'h12345678;
    req_valid = 2'b01; #1;
    step(); req_valid = 2'b00;
    rst = 1'b1;
    step();
    chk("e_rst_valid", 32'(rsp_valid), 32'h0);
    chk("e_rst_data",  rsp_data, 32'h0);
    chk("e_rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("e_no_rsp_%0d", i), 32'(rsp_valid), 32'h0);
    end
    req_valid = 2'b11; #1;
    chk("e_ptr_reset", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00; #1;

    // Lone requester 1 served back-to-back; live op change after accept
    req_op1 = 2'b01; req_a1 = 32'h12345678; req_b1 = 32'h0F0F0F0F;
    req_valid = 2'b10; #1;
    chk("f_ready_a", 32'(req_ready), 32'(2'b10));
    step(); req_op1 = 2'b10;
    step();
    chk("f_rsp_and", rsp_data, 32'h02040608);
    chk("f_rsp_id_a", 32'(rsp_id), 32'(1'b1));
    step();
    chk("f_ready_b", 32'(req_ready), 32'(2'b10));
    step(); req_valid = 2'b00;
    step();
    chk("f_rsp_or", rsp_data, 32'h1F3F5F7F);
    chk("f_rsp_id_b", 32'(rsp_id), 32'(1'b1));
    step();
    chk("f_end_valid", 32'(rsp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
